// File: rtl/decode_mul_pipe_rs_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_mul_pipe_rs_if
// Purpose  : Operand/result handshake bundle for the decode_mul_pipe_rs
//            pipelined multiplier.
// Signals  : flush              - drop everything in flight on the next edge
//            in_valid/in_ready  - operand handshake (din0, din1)
//            out_valid/out_ready- result handshake (dout, sat)
// Modports : master - the side that supplies operands and consumes results
//            slave  - the multiplier
// Revision : 1.0 - initial release
// ============================================================================
interface decode_mul_pipe_rs_if #(
  parameter int DIN0_WIDTH = 40,
  parameter int DIN1_WIDTH = 24,
  parameter int DOUT_WIDTH = 40
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  sat;

  modport master (
    output flush, in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, sat
  );

  modport slave (
    input  flush, in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, sat
  );
endinterface
`default_nettype wire

// File: rtl/decode_mul_pipe_rs.sv
`default_nettype none
// ============================================================================
// Module   : decode_mul_pipe_rs
// Purpose  : NUM_STAGE-deep pipelined multiplier din0 x din1 with per-operand
//            signedness, global valid/ready stall, round-half-up arithmetic
//            right shift by SHIFT and optional saturation to DOUT_WIDTH.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - decode_mul_pipe_rs_if.slave (flush, operand and result
//                    handshakes, dout, sat)
// Revision : 1.0 - initial release
// ============================================================================
module decode_mul_pipe_rs #(
  parameter int DIN0_WIDTH  = 40,
  parameter int DIN1_WIDTH  = 24,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int DOUT_WIDTH  = 40,
  parameter int NUM_STAGE   = 3,
  parameter int SHIFT       = 23,
  parameter int SATURATE    = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  decode_mul_pipe_rs_if.slave   bus
);

  // One guard bit beyond the raw product so mixed-sign products always fit.
  localparam int c_PW = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam bit c_RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  // Half an LSB of the shifted result; zero when SHIFT == 0.
  localparam logic [c_PW:0] c_RND = ({{c_PW{1'b0}}, 1'b1} << SHIFT) >> 1;

  logic                   w_en;
  logic [NUM_STAGE-1:0]   r_vld;
  logic                   w_ext0;
  logic                   w_ext1;
  logic signed [c_PW-1:0] w_a;
  logic signed [c_PW-1:0] w_b;
  logic signed [c_PW-1:0] w_prod;
  logic signed [c_PW-1:0] w_last_prod;
  logic                   w_last_vld;
  logic signed [c_PW:0]   w_sum;
  logic signed [c_PW:0]   w_res;
  logic [DOUT_WIDTH-1:0]  w_dout_nx;
  logic                   w_sat_nx;
  logic [DOUT_WIDTH-1:0]  r_dout;
  logic                   r_sat;

  // Whole pipe advances in lockstep; a stalled output freezes every stage.
  assign w_en          = ~r_vld[NUM_STAGE-1] | bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld[NUM_STAGE-1];
  assign bus.dout      = r_dout;
  assign bus.sat       = r_sat;

  // Operand extension to the full product width.
  assign w_ext0 = (DIN0_SIGNED != 0) && bus.din0[DIN0_WIDTH-1];
  assign w_ext1 = (DIN1_SIGNED != 0) && bus.din1[DIN1_WIDTH-1];
  assign w_a    = {{(c_PW-DIN0_WIDTH){w_ext0}}, bus.din0};
  assign w_b    = {{(c_PW-DIN1_WIDTH){w_ext1}}, bus.din1};
  assign w_prod = w_a * w_b;

  // Valid chain; flush wins over both stall and new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (bus.flush) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld <= (r_vld << 1) | NUM_STAGE'(bus.in_valid);
    end
  end

  // Product registers for stages 1..NUM_STAGE-1. Each register only loads a
  // valid item so idle-cycle operand garbage never propagates toward dout.
  generate
    if (NUM_STAGE == 1) begin : g_single
      assign w_last_prod = w_prod;
      assign w_last_vld  = bus.in_valid;
    end else begin : g_multi
      logic signed [c_PW-1:0] r_prod [NUM_STAGE-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < NUM_STAGE-1; k++) begin
            r_prod[k] <= '0;
          end
        end else if (w_en) begin
          if (bus.in_valid) begin
            r_prod[0] <= w_prod;
          end
          for (int k = 1; k < NUM_STAGE-1; k++) begin
            if (r_vld[k-1]) begin
              r_prod[k] <= r_prod[k-1];
            end
          end
        end
      end

      assign w_last_prod = r_prod[NUM_STAGE-2];
      assign w_last_vld  = r_vld[NUM_STAGE-2];
    end
  endgenerate

  // Round half up then arithmetic shift; one extra bit absorbs the carry.
  assign w_sum = {w_last_prod[c_PW-1], w_last_prod} + c_RND;
  assign w_res = w_sum >>> SHIFT;

  generate
    if ((SATURATE != 0) && c_RES_SIGNED) begin : g_sat_signed
      // In range iff every bit from the dout sign position upward agrees.
      logic [c_PW-DOUT_WIDTH+1:0] w_hi;
      assign w_hi      = w_res[c_PW:DOUT_WIDTH-1];
      assign w_sat_nx  = ~((&w_hi) | ~(|w_hi));
      assign w_dout_nx = w_sat_nx ? {w_res[c_PW], {(DOUT_WIDTH-1){~w_res[c_PW]}}}
                                  : w_res[DOUT_WIDTH-1:0];
    end else if (SATURATE != 0) begin : g_sat_unsigned
      // Unsigned products are never negative, so only the top clamp applies.
      assign w_sat_nx  = |w_res[c_PW:DOUT_WIDTH];
      assign w_dout_nx = w_sat_nx ? '1 : w_res[DOUT_WIDTH-1:0];
    end else begin : g_wrap
      assign w_sat_nx  = 1'b0;
      assign w_dout_nx = w_res[DOUT_WIDTH-1:0];
    end
  endgenerate

  // Output register: holds while stalled or when no valid item arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
      r_sat  <= 1'b0;
    end else if (w_en && w_last_vld) begin
      r_dout <= w_dout_nx;
      r_sat  <= w_sat_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_mul_pipe_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_mul_pipe_rs
// Purpose  : Directed and streamed checks of decode_mul_pipe_rs in four
//            configurations:
//              a: defaults (40s x 24u, 3 stages, SHIFT 23, saturate)
//              b: 8 stages, SHIFT 0, both signed, wrap
//              c: defaults but wrap
//              d: 1 stage, SHIFT 0, both unsigned, saturate
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_mul_pipe_rs;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;

  always #5 clk = ~clk;

  decode_mul_pipe_rs_if ba ();
  decode_mul_pipe_rs_if bb ();
  decode_mul_pipe_rs_if bc ();
  decode_mul_pipe_rs_if bd ();

  decode_mul_pipe_rs dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  decode_mul_pipe_rs #(.NUM_STAGE(8), .SHIFT(0), .DIN1_SIGNED(1), .SATURATE(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
  decode_mul_pipe_rs #(.SATURATE(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bc));
  decode_mul_pipe_rs #(.NUM_STAGE(1), .SHIFT(0), .DIN0_SIGNED(0), .DIN1_SIGNED(0))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(bd));

  // ---------------------------------------------------------------- checking
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Straight arithmetic reference: 128-bit signed math per configuration.
  function automatic logic [40:0] ref_model(int sel, logic [39:0] d0, logic [23:0] d1);
    bit s0, s1, sat;
    int sh;
    logic signed [127:0] a, b, p, r, mx, mn;
    case (sel)
      0:       begin s0 = 1; s1 = 0; sh = 23; sat = 1; end
      1:       begin s0 = 1; s1 = 1; sh = 0;  sat = 0; end
      2:       begin s0 = 1; s1 = 0; sh = 23; sat = 0; end
      default: begin s0 = 0; s1 = 0; sh = 0;  sat = 1; end
    endcase
    a = {{88{s0 & d0[39]}}, d0};
    b = {{104{s1 & d1[23]}}, d1};
    p = a * b;
    if (sh > 0) r = (p + (128'sd1 <<< (sh - 1))) >>> sh;
    else        r = p;
    if (!sat) return {1'b0, r[39:0]};
    if (s0 | s1) begin
      mx = (128'sd1 <<< 39) - 128'sd1;
      mn = -(128'sd1 <<< 39);
    end else begin
      mx = (128'sd1 <<< 40) - 128'sd1;
      mn = 128'sd0;
    end
    if (r > mx) return {1'b1, mx[39:0]};
    if (r < mn) return {1'b1, mn[39:0]};
    return {1'b0, r[39:0]};
  endfunction

  // ------------------------------------------------------- bus access helpers
  task automatic set_in(int sel, logic v, logic [39:0] d0, logic [23:0] d1);
    case (sel)
      0:       begin ba.in_valid = v; ba.din0 = d0; ba.din1 = d1; end
      1:       begin bb.in_valid = v; bb.din0 = d0; bb.din1 = d1; end
      2:       begin bc.in_valid = v; bc.din0 = d0; bc.din1 = d1; end
      default: begin bd.in_valid = v; bd.din0 = d0; bd.din1 = d1; end
    endcase
  endtask

  task automatic set_rdy(int sel, logic r);
    case (sel)
      0:       ba.out_ready = r;
      1:       bb.out_ready = r;
      2:       bc.out_ready = r;
      default: bd.out_ready = r;
    endcase
  endtask

  function automatic logic get_ov(int sel);
    case (sel)
      0:       return ba.out_valid;
      1:       return bb.out_valid;
      2:       return bc.out_valid;
      default: return bd.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(int sel);
    case (sel)
      0:       return ba.in_ready;
      1:       return bb.in_ready;
      2:       return bc.in_ready;
      default: return bd.in_ready;
    endcase
  endfunction

  function automatic logic get_sat(int sel);
    case (sel)
      0:       return ba.sat;
      1:       return bb.sat;
      2:       return bc.sat;
      default: return bd.sat;
    endcase
  endfunction

  function automatic logic [39:0] get_dout(int sel);
    case (sel)
      0:       return ba.dout;
      1:       return bb.dout;
      2:       return bc.dout;
      default: return bd.dout;
    endcase
  endfunction

  // One operand pair, out_ready high; checks latency, dout and sat.
  // Entered and left one time unit after a rising edge.
  task automatic run(int sel, logic [39:0] d0, logic [23:0] d1,
                     logic [39:0] ed, logic es, int lat, string tag);
    int k = 0;
    set_in(sel, 1'b1, d0, d1);
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) set_in(sel, 1'b0, 'x, 'x);
    end while (!get_ov(sel) && k < 40);
    chk({tag, "_lat"},  64'(k),              64'(lat));
    chk({tag, "_dout"}, 64'(get_dout(sel)),  64'(ed));
    chk({tag, "_sat"},  64'(get_sat(sel)),   64'(es));
  endtask

  task automatic pick(output logic [39:0] d0, output logic [23:0] d1);
    logic [19:0] t;
    t = 20'($urandom());
    if ($urandom_range(0, 1) == 0) d0 = {{20{t[19]}}, t};
    else                           d0 = 40'({$urandom(), $urandom()});
    d1 = 24'($urandom());
  endtask

  // Streams n operand pairs, optionally with random back-pressure, and
  // scoreboards results in order against the reference model.
  task automatic stream(int sel, int n, bit rnd);
    logic [40:0] q[$];
    logic [40:0] prev = '0;
    logic [40:0] obsv;
    logic [39:0] d0;
    logic [23:0] d1;
    logic        ordy, ov, ir;
    bit          exp_ir;
    bit          stalled = 0;
    int          sent = 0, got = 0, cyc = 0;
    pick(d0, d1);
    while (got < n && cyc < n * 8 + 100) begin
      @(posedge clk); #1;
      cyc++;
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_rdy(sel, ordy);
      if (sent < n) set_in(sel, 1'b1, d0, d1);
      else          set_in(sel, 1'b0, 'x, 'x);
      #1;
      ov     = get_ov(sel);
      ir     = get_ir(sel);
      obsv   = {get_sat(sel), get_dout(sel)};
      exp_ir = ~ov | ordy;
      chk("in_ready_comb", 64'(ir), 64'(exp_ir));
      if (stalled) begin
        chk("stall_valid", 64'(ov), 64'(1));
        chk("stall_hold", 64'(obsv), 64'(prev));
      end
      if (ov && ordy) begin
        if (q.size() == 0) chk("spurious_ov", 64'(ov), 64'(0));
        else begin
          chk("stream_data", 64'(obsv), 64'(q.pop_front()));
          got++;
        end
      end
      if (sent < n && ir) begin
        q.push_back(ref_model(sel, d0, d1));
        sent++;
        pick(d0, d1);
      end
      stalled = ov & ~ordy;
      prev    = obsv;
    end
    chk("stream_count", 64'(got), 64'(n));
    chk("stream_left", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
    set_in(sel, 1'b0, 'x, 'x);
    set_rdy(sel, 1'b1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int s = 0; s < 4; s++) begin
      set_in(s, 1'b0, 'x, 'x);
      set_rdy(s, 1'b1);
    end
    ba.flush = 1'b0; bb.flush = 1'b0; bc.flush = 1'b0; bd.flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ba.out_valid), 64'(0));
    chk("rst_dout",      64'(ba.dout),      64'(0));
    chk("rst_sat",       64'(ba.sat),       64'(0));
    chk("rst_in_ready",  64'(ba.in_ready),  64'(1));
    chk("rst_b_valid",   64'(bb.out_valid), 64'(0));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // -1 * 2^23 >> 23 -> -1
    run(0, 40'hFF_FFFF_FFFF, 24'h80_0000, 40'hFF_FFFF_FFFF, 1'b0, 3, "neg_one");
    // Round half up on exact ties
    run(0, 40'd3,            24'h40_0000, 40'd2,            1'b0, 3, "rnd_p3");
    run(0, 40'hFF_FFFF_FFFD, 24'h40_0000, 40'hFF_FFFF_FFFF, 1'b0, 3, "rnd_m3");
    run(0, 40'd1,            24'h40_0000, 40'd1,            1'b0, 3, "rnd_p1");
    // Saturation extremes
    run(0, 40'h7F_FFFF_FFFF, 24'hFF_FFFF, 40'h7F_FFFF_FFFF, 1'b1, 3, "sat_pos");
    run(0, 40'h80_0000_0000, 24'hFF_FFFF, 40'h80_0000_0000, 1'b1, 3, "sat_neg");
    // Same operands, wrapping build
    run(2, 40'h7F_FFFF_FFFF, 24'hFF_FFFF, 40'hFF_FFFE_FFFE, 1'b0, 3, "wrap_pos");
    run(2, 40'h80_0000_0000, 24'hFF_FFFF, 40'h00_0001_0000, 1'b0, 3, "wrap_neg");

    // Flush with two items in flight and a third accepted in the flush cycle
    set_in(0, 1'b1, 40'd11, 24'h80_0000);
    @(posedge clk); #1;
    set_in(0, 1'b1, 40'd12, 24'h80_0000);
    @(posedge clk); #1;
    set_in(0, 1'b1, 40'd13, 24'h80_0000);
    ba.flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(ba.in_ready), 64'(1));
    @(posedge clk); #1;
    ba.flush = 1'b0;
    set_in(0, 1'b0, 'x, 'x);
    repeat (6) begin
      chk("flush_no_valid", 64'(ba.out_valid), 64'(0));
      @(posedge clk); #1;
    end
    run(0, 40'd1000, 24'h80_0000, 40'd1000, 1'b0, 3, "post_flush");

    // Asynchronous reset mid-stream
    set_in(0, 1'b1, 40'd7, 24'h80_0000);
    @(posedge clk); #1;
    set_in(0, 1'b1, 40'd9, 24'h80_0000);
    @(posedge clk); #1;
    set_in(0, 1'b0, 'x, 'x);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(ba.out_valid), 64'(0));
    chk("arst_dout",      64'(ba.dout),      64'(0));
    chk("arst_sat",       64'(ba.sat),       64'(0));
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("arst_no_stale", 64'(ba.out_valid), 64'(0));
    end
    run(0, 40'd5, 24'h80_0000, 40'd5, 1'b0, 3, "post_arst");

    // 8 stages, both signed, SHIFT 0, wrap
    run(1, 40'd5,            24'hFF_FFFF, 40'hFF_FFFF_FFFB, 1'b0, 8, "s8_m5");
    run(1, 40'h7F_FFFF_FFFF, 24'h7F_FFFF, 40'h7F_FF80_0001, 1'b0, 8, "s8_wrap");
    // 1 stage, both unsigned, SHIFT 0, saturate
    run(3, 40'd7,            24'd6,       40'd42,           1'b0, 1, "s1_small");
    run(3, 40'hFF_FFFF_FFFF, 24'd1,       40'hFF_FFFF_FFFF, 1'b0, 1, "s1_edge");
    run(3, 40'hFF_FFFF_FFFF, 24'd2,       40'hFF_FFFF_FFFF, 1'b1, 1, "s1_sat");

    // Streams against the reference model
    stream(0, 40,   1'b1);
    stream(1, 1000, 1'b0);
    stream(3, 1000, 1'b0);
    stream(1, 100,  1'b1);
    stream(2, 40,   1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
